btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameters: N_BTN, default 6, number of keypad buttons.
REQ-002 Parameters: DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a level change.
REQ-003 Parameters: CNT_W, default 20, debounce counter width; it SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-004 Ports: clk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 Ports: rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 Ports: btn_raw  in  N_BTN  asynchronous, bouncing, active-high button levels.
REQ-007 Ports: btns  out  N_BTN  registered one-cycle press pulses; this bus drives the passcode-entry stage directly.
REQ-008 Ports: held  out  N_BTN  registered debounced button levels.
REQ-009 Ports: digit  out  3  registered code of the pulsed button (index k gives k+1), 0 when btns is all zero.
REQ-010 Ports: press  out  1  registered; SHALL equal the OR of btns.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per button, a counter SHALL increment each cycle that sync[k] != held[k], and SHALL clear on any cycle where they are equal.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, held[k] SHALL take sync[k] on that edge, and the counter SHALL clear.
REQ-014 A bounce (any single-cycle return to equality) SHALL restart the count from 0, so no partial credit is kept.
REQ-015 A debounced rise is the cycle where held[k] goes 0->1; btns[k] SHALL pulse high for exactly one cycle, registered one edge after that rise.
REQ-016 Latency: for a clean raw rise first sampled at edge E, held[k] SHALL rise at edge E+1+DEBOUNCE_CYCLES and btns[k] SHALL pulse at edge E+2+DEBOUNCE_CYCLES.
REQ-017 Falls of held SHALL produce no pulse, and there SHALL be no auto-repeat while a button is held.
REQ-018 Simultaneous debounced rises: only the lowest index SHALL pulse; the other buttons SHALL update held but never pulse for that press.
REQ-019 Ghost suppression: a rise on button k SHALL NOT pulse if any other held[j] (j != k) was already 1 on the previous cycle.
REQ-020 At most one btns bit SHALL be high in any cycle.
REQ-021 digit and press SHALL be cycle-aligned with btns.
REQ-022 The counter SHALL never wrap; it is bounded by the REQ-013 clear.

Reset
REQ-023 While rst_n=0 at an edge, the synchronizers, held, counters, btns, digit and press SHALL all load 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.
REQ-025 If a button is still physically pressed after reset, it SHALL produce one pulse after a full DEBOUNCE_CYCLES interval from the first post-reset sample.

Structure
REQ-026 Shared package m16_pkg SHALL hold N_BTN, the 3-bit digit width, and the digit encodings NONE=0 through BTN6=6.
REQ-027 One sub-module, btn_debounce (synchronizer, counter and held level for a single channel), SHALL be instantiated N_BTN times.
REQ-028 The rise detect, priority, ghost filter and encode logic SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4 for sim)
REQ-029 Clean press: btn_raw[2] 0->1 held 20 cycles -> one btns=6'b000100, digit=3, press=1 at E+6; nothing further while held.
REQ-030 Bounce: btn_raw[0] toggles 1,0,1,0 per cycle, then stays 1 -> single pulse, digit=1, 6 cycles after the final stable 1 is sampled.
REQ-031 Glitch: btn_raw[4] high for 3 cycles then low -> held[4] stays 0 and no pulse.
REQ-032 Simultaneous: btn_raw[1] and btn_raw[3] rise on the same edge -> only btns[1] pulses, digit=2; held=6'b001010.
REQ-033 Ghost: hold button 5, then press button 0 -> no pulse for button 0; release both, then press button 0 -> pulse with digit=1.
REQ-034 Reset mid-debounce: rst_n=0 for 1 cycle during a count -> all outputs 0 the next cycle; a button still held pulses exactly 6 cycles after reset deasserts.

Source files
------------

// File: rtl/m16_pkg.sv
// Shared keypad constants: button count, digit width and the digit codes
// reported for each pulsed button.
package m16_pkg;
  localparam int N_BTN   = 6;
  localparam int DIGIT_W = 3;

  typedef enum logic [DIGIT_W-1:0] {
    NONE = 3'd0,
    BTN1 = 3'd1,
    BTN2 = 3'd2,
    BTN3 = 3'd3,
    BTN4 = 3'd4,
    BTN5 = 3'd5,
    BTN6 = 3'd6
  } digit_e;

  // Button index k reports as digit k+1; 0 is reserved for "no press".
  function automatic logic [DIGIT_W-1:0] btn_code(input int idx);
    return DIGIT_W'(idx + 1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Single button channel: 2-flop synchronizer followed by a stable-run counter
// that commits a new level only after DEBOUNCE_CYCLES consecutive mismatches.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic held
);
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      held <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any cycle of agreement drops the run, so a bounce restarts from zero.
      if (sync[1] != held) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          held <= sync[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// Keypad front end: per-button debounce, then one registered press pulse per
// debounced rise with lowest-index priority and ghost-press suppression.
module btn_conditioner #(
  parameter int N_BTN           = m16_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btns,
  output logic [N_BTN-1:0] held,
  output logic [2:0]       digit,
  output logic             press
);
  import m16_pkg::*;

  logic [N_BTN-1:0]   held_q;
  logic [N_BTN-1:0]   rise;
  logic [N_BTN-1:0]   pulse_nxt;
  logic [N_BTN-1:0]   others;
  logic [DIGIT_W-1:0] digit_nxt;
  logic               found;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db [N_BTN-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_raw),
    .held (held)
  );

  assign rise = held & ~held_q;

  // A rise only counts if no other button was already down the cycle before;
  // among simultaneous qualifying rises the lowest index wins.
  always_comb begin
    pulse_nxt = '0;
    digit_nxt = NONE;
    found     = 1'b0;
    others    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      others    = held_q;
      others[k] = 1'b0;
      if (!found && rise[k] && (others == '0)) begin
        pulse_nxt[k] = 1'b1;
        digit_nxt    = btn_code(k);
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q <= '0;
      btns   <= '0;
      digit  <= '0;
      press  <= 1'b0;
    end else begin
      held_q <= held;
      btns   <= pulse_nxt;
      digit  <= digit_nxt;
      press  <= found;
    end
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a short debounce interval.
module tb_btn_conditioner;
  localparam int NB = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btns;
  logic [NB-1:0] held;
  logic [2:0]    digit;
  logic          press;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(.N_BTN(NB), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .btns   (btns),
    .held   (held),
    .digit  (digit),
    .press  (press)
  );

  always #5 clk = ~clk;

  // Drives new_raw from the current negedge (sampled at edge E), switches to
  // rel_raw at window cycle 'hold', and observes n negedges. Window cycle i is
  // sampled just after edge E+i-1, so a pulse at E+6 shows up at i=7.
  task automatic watch(input logic [NB-1:0] new_raw, input logic [NB-1:0] rel_raw,
                       input int hold, input int n,
                       output int npulse, output int first_idx,
                       output logic [NB-1:0] fb, output logic [2:0] fd,
                       output logic fp, output logic [NB-1:0] hseen, output int bad);
    npulse = 0; first_idx = -1; fb = '0; fd = '0; fp = 1'b0; hseen = '0; bad = 0;
    btn_raw = new_raw;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == hold) btn_raw = rel_raw;
      hseen = hseen | held;
      if (btns != '0) begin
        npulse++;
        if (first_idx < 0) begin
          first_idx = i; fb = btns; fd = digit; fp = press;
        end
      end
      if ((press !== (|btns)) || ($countones(btns) > 1) || ((btns == '0) && (digit != 3'd0)))
        bad++;
    end
  endtask

  int np, fi, bad;
  logic [NB-1:0] fb, hs;
  logic [2:0] fd;
  logic fp;

  task automatic test_reset();
    rst_n = 1'b0; btn_raw = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({btns, held, digit, press} !== '0) begin
      errors++; $display("FAIL reset_outputs got btns=%b held=%b digit=%0d press=%b want all 0", btns, held, digit, press);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    watch(6'b000100, 6'b000100, 0, 20, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1) begin errors++; $display("FAIL clean_npulse got %0d want 1", np); end
    checks++; if (fi != 7) begin errors++; $display("FAIL clean_latency got %0d want 7", fi); end
    checks++; if (fb !== 6'b000100 || fd !== 3'd3 || fp !== 1'b1) begin
      errors++; $display("FAIL clean_pulse got btns=%b digit=%0d press=%b want 000100 3 1", fb, fd, fp); end
    checks++; if (held !== 6'b000100) begin errors++; $display("FAIL clean_held got %b want 000100", held); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clean_consistency got %0d want 0", bad); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 0 || held !== 6'b0) begin
      errors++; $display("FAIL clean_release got npulse=%0d held=%b want 0 000000", np, held); end
  endtask

  task automatic test_bounce();
    btn_raw = 6'b000001; @(negedge clk);
    btn_raw = 6'b000000; @(negedge clk);
    btn_raw = 6'b000001; @(negedge clk);
    btn_raw = 6'b000000; @(negedge clk);
    watch(6'b000001, 6'b000001, 0, 15, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fi != 7) begin
      errors++; $display("FAIL bounce_pulse got npulse=%0d at=%0d want 1 at 7", np, fi); end
    checks++; if (fb !== 6'b000001 || fd !== 3'd1) begin
      errors++; $display("FAIL bounce_digit got btns=%b digit=%0d want 000001 1", fb, fd); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
  endtask

  task automatic test_glitch();
    watch(6'b010000, 6'b0, 3, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 0 || hs !== 6'b0) begin
      errors++; $display("FAIL glitch got npulse=%0d held_seen=%b want 0 000000", np, hs); end
  endtask

  task automatic test_boundary();
    watch(6'b010000, 6'b0, 4, 16, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fi != 7 || fd !== 3'd5) begin
      errors++; $display("FAIL boundary_pulse got npulse=%0d at=%0d digit=%0d want 1 7 5", np, fi, fd); end
    checks++; if (hs !== 6'b010000 || held !== 6'b0) begin
      errors++; $display("FAIL boundary_held got seen=%b now=%b want 010000 000000", hs, held); end
  endtask

  task automatic test_simul();
    watch(6'b001010, 6'b001010, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fb !== 6'b000010 || fd !== 3'd2) begin
      errors++; $display("FAIL simul_pulse got npulse=%0d btns=%b digit=%0d want 1 000010 2", np, fb, fd); end
    checks++; if (held !== 6'b001010) begin errors++; $display("FAIL simul_held got %b want 001010", held); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 0) begin errors++; $display("FAIL simul_release got %0d want 0", np); end
  endtask

  task automatic test_ghost();
    watch(6'b100000, 6'b100000, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fd !== 3'd6) begin
      errors++; $display("FAIL ghost_first got npulse=%0d digit=%0d want 1 6", np, fd); end
    watch(6'b100001, 6'b100001, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 0 || held !== 6'b100001) begin
      errors++; $display("FAIL ghost_suppress got npulse=%0d held=%b want 0 100001", np, held); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
    watch(6'b000001, 6'b000001, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fi != 7 || fd !== 3'd1) begin
      errors++; $display("FAIL ghost_after got npulse=%0d at=%0d digit=%0d want 1 7 1", np, fi, fd); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
  endtask

  task automatic test_rst_mid();
    watch(6'b001000, 6'b001000, 0, 12, np, fi, fb, fd, fp, hs, bad);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({btns, held, digit, press} !== '0) begin
      errors++; $display("FAIL rst_outputs got btns=%b held=%b digit=%0d press=%b want all 0", btns, held, digit, press); end
    rst_n = 1'b1;
    watch(6'b001000, 6'b001000, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fi != 7 || fd !== 3'd4) begin
      errors++; $display("FAIL rst_repress got npulse=%0d at=%0d digit=%0d want 1 7 4", np, fi, fd); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
    btn_raw = 6'b000100;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    watch(6'b000100, 6'b000100, 0, 12, np, fi, fb, fd, fp, hs, bad);
    checks++; if (np != 1 || fi != 7 || fd !== 3'd3) begin
      errors++; $display("FAIL rst_middebounce got npulse=%0d at=%0d digit=%0d want 1 7 3", np, fi, fd); end
    watch(6'b0, 6'b0, 0, 12, np, fi, fb, fd, fp, hs, bad);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_raw = '0;
    @(negedge clk);
    test_reset();
    test_clean();
    test_bounce();
    test_glitch();
    test_boundary();
    test_simul();
    test_ghost();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
